// File: rtl/vga_timing_gen_if.sv
// Raster-side bundle: coordinates/blank out to the image blocks, colour back,
// and the re-aligned sync/colour pins toward the DAC.
interface vga_timing_gen_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       blank_n;
    logic       frame_start;
    logic [7:0] img_red;
    logic [7:0] img_green;
    logic [7:0] img_blue;
    logic [7:0] vga_red;
    logic [7:0] vga_green;
    logic [7:0] vga_blue;
    logic       vga_hsync_n;
    logic       vga_vsync_n;
    logic       vga_blank_out_n;

    modport master (
        output pixel_x, pixel_y, blank_n, frame_start,
        output vga_red, vga_green, vga_blue, vga_hsync_n, vga_vsync_n, vga_blank_out_n,
        input  img_red, img_green, img_blue
    );

    modport slave (
        input  pixel_x, pixel_y, blank_n, frame_start,
        input  vga_red, vga_green, vga_blue, vga_hsync_n, vga_vsync_n, vga_blank_out_n,
        output img_red, img_green, img_blue
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, registered stage-0 position,
// and a PIX_LAT-deep sync/blank delay so DAC pins line up with returned colour.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_LAT  = 1
) (
    input  logic              vga_clk,
    input  logic              arst_n,
    vga_timing_gen_if.master  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] pixel_x, pixel_y;
    logic       frame_start;
    sync_t      pipe [PIX_LAT:0];

    logic [7:0] vga_red, vga_green, vga_blue;
    logic       vga_hsync_n, vga_vsync_n, vga_blank_out_n;

    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Stage 0 registers the counter position together with its decodes, so
    // the first edge out of reset shows (0,0) with blank_n and frame_start set.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i <= PIX_LAT; i++) pipe[i] <= '0;
        end else begin
            pixel_x        <= h_cnt;
            pixel_y        <= v_cnt;
            frame_start    <= (h_cnt == '0) && (v_cnt == '0);
            pipe[0].hs     <= (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
            pipe[0].vs     <= (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
            pipe[0].blank  <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            for (int i = 1; i <= PIX_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Output register samples img_* on the same edge as the delayed blank.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            vga_hsync_n     <= 1'b1;
            vga_vsync_n     <= 1'b1;
            vga_blank_out_n <= 1'b0;
            vga_red         <= '0;
            vga_green       <= '0;
            vga_blue        <= '0;
        end else begin
            vga_hsync_n     <= ~pipe[PIX_LAT].hs;
            vga_vsync_n     <= ~pipe[PIX_LAT].vs;
            vga_blank_out_n <= pipe[PIX_LAT].blank;
            vga_red         <= pipe[PIX_LAT].blank ? vif.img_red   : 8'h00;
            vga_green       <= pipe[PIX_LAT].blank ? vif.img_green : 8'h00;
            vga_blue        <= pipe[PIX_LAT].blank ? vif.img_blue  : 8'h00;
        end
    end

    assign vif.pixel_x         = pixel_x;
    assign vif.pixel_y         = pixel_y;
    assign vif.blank_n         = pipe[0].blank;
    assign vif.frame_start     = frame_start;
    assign vif.vga_red         = vga_red;
    assign vif.vga_green       = vga_green;
    assign vif.vga_blue        = vga_blue;
    assign vif.vga_hsync_n     = vga_hsync_n;
    assign vif.vga_vsync_n     = vga_vsync_n;
    assign vif.vga_blank_out_n = vga_blank_out_n;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: four geometries/latencies run side by side against a position-arithmetic
// model; red carries the column via a modelled image delay, green/blue are random.
module tb_vga_timing_gen;
    localparam int N = 4;
    localparam int HA_T [N] = '{640, 20, 20, 10};
    localparam int HF_T [N] = '{ 16,  3,  3,  2};
    localparam int HS_T [N] = '{ 96,  5,  5,  3};
    localparam int HB_T [N] = '{ 48,  4,  4,  1};
    localparam int VA_T [N] = '{480, 12, 12,  5};
    localparam int VF_T [N] = '{ 10,  2,  2,  1};
    localparam int VS_T [N] = '{  2,  2,  2,  1};
    localparam int VB_T [N] = '{ 33,  3,  3,  2};
    localparam int L_T  [N] = '{  1,  0,  1,  3};

    logic vga_clk = 1'b0;
    logic arst_n  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    event rst_chk;

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int HA = HA_T[g], HF = HF_T[g], HS = HS_T[g], HB = HB_T[g];
        localparam int VA = VA_T[g], VF = VF_T[g], VS = VS_T[g], VB = VB_T[g];
        localparam int L  = L_T[g];
        localparam int HT = HA + HF + HS + HB;
        localparam int VT = VA + VF + VS + VB;

        vga_timing_gen_if vif ();

        vga_timing_gen #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .PIX_LAT(L)
        ) dut (
            .vga_clk (vga_clk),
            .arst_n  (arst_n),
            .vif     (vif.master)
        );

        int         k;        // clock edges since reset release
        logic [7:0] xh [0:3]; // pixel_x history, models the image-block latency

        initial begin
            vif.img_red   = 8'h00;
            vif.img_green = 8'h00;
            vif.img_blue  = 8'h00;
            for (int i = 0; i < 4; i++) xh[i] = 8'h00;
        end

        always @(posedge vga_clk or negedge arst_n)
            if (!arst_n) k <= 0;
            else         k <= k + 1;

        always @(negedge vga_clk) begin
            int p, x, y, bl, fs, ox, oy, hs, vs, ob;
            if (arst_n) begin
                // Stage 0 after edge k shows raster position k-1.
                if (k == 0) begin
                    x = 0; y = 0; bl = 0; fs = 0;
                end else begin
                    p  = k - 1;
                    x  = p % HT;
                    y  = (p / HT) % VT;
                    bl = (x < HA && y < VA) ? 1 : 0;
                    fs = (p % (HT * VT) == 0) ? 1 : 0;
                end
                check($sformatf("u%0d.pixel_x", g),     int'(vif.pixel_x),     x);
                check($sformatf("u%0d.pixel_y", g),     int'(vif.pixel_y),     y);
                check($sformatf("u%0d.blank_n", g),     int'(vif.blank_n),     bl);
                check($sformatf("u%0d.frame_start", g), int'(vif.frame_start), fs);
                // DAC pins after edge k show position k-L-2.
                if (k < L + 2) begin
                    ox = 0; oy = 0; hs = 0; vs = 0; ob = 0;
                end else begin
                    p  = k - L - 2;
                    ox = p % HT;
                    oy = (p / HT) % VT;
                    hs = (ox >= HA + HF && ox < HA + HF + HS) ? 1 : 0;
                    vs = (oy >= VA + VF && oy < VA + VF + VS) ? 1 : 0;
                    ob = (ox < HA && oy < VA) ? 1 : 0;
                end
                check($sformatf("u%0d.vga_hsync_n", g),     int'(vif.vga_hsync_n),     1 - hs);
                check($sformatf("u%0d.vga_vsync_n", g),     int'(vif.vga_vsync_n),     1 - vs);
                check($sformatf("u%0d.vga_blank_out_n", g), int'(vif.vga_blank_out_n), ob);
                check($sformatf("u%0d.vga_red", g),   int'(vif.vga_red),   ob ? (ox % 256) : 0);
                check($sformatf("u%0d.vga_green", g), int'(vif.vga_green), ob ? int'(vif.img_green) : 0);
                check($sformatf("u%0d.vga_blue", g),  int'(vif.vga_blue),  ob ? int'(vif.img_blue) : 0);
            end
            vif.img_red = (L == 0) ? vif.pixel_x[7:0] : xh[(L == 0) ? 0 : L - 1];
            for (int i = 3; i > 0; i--) xh[i] = xh[i-1];
            xh[0] = vif.pixel_x[7:0];
            vif.img_green = 8'($urandom);
            vif.img_blue  = 8'($urandom);
        end

        always begin
            @(rst_chk);
            check($sformatf("u%0d.rst.pixel_x", g),     int'(vif.pixel_x),         0);
            check($sformatf("u%0d.rst.pixel_y", g),     int'(vif.pixel_y),         0);
            check($sformatf("u%0d.rst.blank_n", g),     int'(vif.blank_n),         0);
            check($sformatf("u%0d.rst.frame_start", g), int'(vif.frame_start),     0);
            check($sformatf("u%0d.rst.hsync_n", g),     int'(vif.vga_hsync_n),     1);
            check($sformatf("u%0d.rst.vsync_n", g),     int'(vif.vga_vsync_n),     1);
            check($sformatf("u%0d.rst.blank_out", g),   int'(vif.vga_blank_out_n), 0);
            check($sformatf("u%0d.rst.rgb", g),
                  int'({vif.vga_red, vif.vga_green, vif.vga_blue}), 0);
        end
    end

    initial begin
        #23;
        -> rst_chk;
        #4 arst_n = 1'b1;
        // Several small frames and a few full 640-wide lines.
        repeat (3000 + $urandom_range(0, 200)) @(posedge vga_clk);
        // Mid-frame asynchronous reset, checked before any further clock edge.
        #2 arst_n = 1'b0;
        #1 -> rst_chk;
        repeat (3) @(posedge vga_clk);
        #2 arst_n = 1'b1;
        repeat (1500) @(posedge vga_clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
